execute_mem_stage: RTL and testbench

EXECUTE_MEM_STAGE -- requirements
Module: execute_mem_stage

---
 rtl/execute_mem_pkg.sv | 40 ++++
 rtl/execute_mem_alu.sv | 32 +++
 rtl/execute_mem_stage.sv | 265 ++++++++++++++++++++++++++
 tb/tb_execute_mem_stage.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/execute_mem_pkg.sv
// Shared opcode/funct3 constants, FSM state type and lane-mask helper for execute_mem_stage.
package execute_mem_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_BUS_REQ   = 2'd1,
    ST_READ_WAIT = 2'd2
  } state_e;

  // Size mask shifted to the byte offset; lanes past bit 3 are dropped.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] ofs);
    logic [7:0] m;
    case (size)
      2'b00:   m = 8'b0000_0001;
      2'b01:   m = 8'b0000_0011;
      default: m = 8'b0000_1111;
    endcase
    m = m << ofs;
    return m[3:0];
  endfunction

endpackage

// File: rtl/execute_mem_alu.sv
// RV32I integer ALU with comparison flags used for branch resolution.
module execute_mem_alu (
  input  logic [31:0] op_a_i,
  input  logic [31:0] op_b_i,
  input  logic [2:0]  funct3_i,
  input  logic        alt_i,
  output logic [31:0] result_o,
  output logic        eq_o,
  output logic        lt_o,
  output logic        ltu_o
);
  logic [4:0] shamt;

  assign shamt = op_b_i[4:0];
  assign eq_o  = (op_a_i == op_b_i);
  assign lt_o  = ($signed(op_a_i) < $signed(op_b_i));
  assign ltu_o = (op_a_i < op_b_i);

  always_comb begin
    result_o = 32'd0;
    case (funct3_i)
      3'b000:  result_o = alt_i ? (op_a_i - op_b_i) : (op_a_i + op_b_i);
      3'b001:  result_o = op_a_i << shamt;
      3'b010:  result_o = {31'd0, lt_o};
      3'b011:  result_o = {31'd0, ltu_o};
      3'b100:  result_o = op_a_i ^ op_b_i;
      3'b101:  result_o = alt_i ? 32'($signed(op_a_i) >>> shamt) : (op_a_i >> shamt);
      3'b110:  result_o = op_a_i | op_b_i;
      default: result_o = op_a_i & op_b_i;
    endcase
  end
endmodule

// File: rtl/execute_mem_stage.sv
// RV32I execute + memory stage with a single-outstanding bus master.
// Optional macro EXECUTE_MEM_MISALIGN_CHECK_EN turns misaligned loads/stores into faults.
module execute_mem_stage
  import execute_mem_pkg::*;
#(
  parameter int BUS_ADDR_WIDTH    = 30,
  parameter int RESULT_REGISTERED = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  output logic                      ready,
  input  logic [29:0]               pc_value,
  input  logic [31:0]               instruction,
  input  logic [31:0]               rs1_value,
  input  logic [31:0]               rs2_value,
  output logic                      result_valid,
  output logic [4:0]                rd,
  output logic [31:0]               next_pc,
  output logic                      rd_write_enable,
  output logic [31:0]               rd_write_data,
  output logic [BUS_ADDR_WIDTH-1:0] bus_addr,
  output logic [3:0]                bus_byte_enable,
  output logic [31:0]               bus_write_data,
  output logic                      bus_write_req,
  output logic                      bus_read_req,
  input  logic                      bus_ready,
  input  logic [31:0]               bus_read_data,
  input  logic                      bus_read_data_valid
`ifdef EXECUTE_MEM_MISALIGN_CHECK_EN
  ,
  output logic                      misaligned
`endif
);
  localparam bit REG_OUT = (RESULT_REGISTERED != 0);

  // Handshake: an instruction transfers on the rising edge where enable && ready.
  // The bus request transfers on the edge where it is asserted and bus_ready is high;
  // request, address, lanes and data stay constant until then.
  state_e state_q, state_d;
  logic [6:0]  opc;
  logic [4:0]  rd_field;
  logic [2:0]  f3;
  logic [31:0] pc32, pc_plus4, imm_i, imm_s, imm_b, imm_j, imm_u;
  logic [31:0] alu_b, alu_res, eff_addr, st_data, lane_data, ld_data;
  logic [31:0] ex_data, ex_next_pc;
  logic        alu_alt, eq, lt, ltu, taken, ex_we, is_load, is_store, is_mem, accept, bypass;

  logic                      rv_q, rv_d, we_q, we_d, wreq_q, wreq_d, rreq_q, rreq_d;
  logic                      mis_q, mis_d;
  logic [4:0]                rd_q, rd_d;
  logic [31:0]               npc_q, npc_d, data_q, data_d, bwd_q, bwd_d;
  logic [BUS_ADDR_WIDTH-1:0] baddr_q, baddr_d;
  logic [3:0]                be_q, be_d;
  logic [2:0]                f3_q, f3_d;
  logic [1:0]                ofs_q, ofs_d;

  assign opc      = instruction[6:0];
  assign rd_field = instruction[11:7];
  assign f3       = instruction[14:12];
  assign pc32     = {pc_value, 2'b00};
  assign pc_plus4 = pc32 + 32'd4;
  assign imm_i = {{20{instruction[31]}}, instruction[31:20]};
  assign imm_s = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
  assign imm_b = {{19{instruction[31]}}, instruction[31], instruction[7],
                  instruction[30:25], instruction[11:8], 1'b0};
  assign imm_j = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                  instruction[20], instruction[30:21], 1'b0};
  assign imm_u = {instruction[31:12], 12'd0};

  assign is_load  = (opc == OPC_LOAD);
  assign is_store = (opc == OPC_STORE);
  assign is_mem   = is_load || is_store;
  assign accept   = enable && (state_q == ST_IDLE);
  assign eff_addr = rs1_value + (is_store ? imm_s : imm_i);

  // Only OP uses bit 30 for SUB; OP-IMM uses it solely to pick SRAI over SRLI.
  assign alu_b   = (opc == OPC_OPIMM) ? imm_i : rs2_value;
  assign alu_alt = instruction[30] && ((opc == OPC_OP) || (f3 == 3'b101));

  execute_mem_alu u_alu (
    .op_a_i   (rs1_value),
    .op_b_i   (alu_b),
    .funct3_i (f3),
    .alt_i    (alu_alt),
    .result_o (alu_res),
    .eq_o     (eq),
    .lt_o     (lt),
    .ltu_o    (ltu)
  );

  always_comb begin
    case (f3)
      3'b000:  taken = eq;
      3'b001:  taken = !eq;
      3'b100:  taken = lt;
      3'b101:  taken = !lt;
      3'b110:  taken = ltu;
      3'b111:  taken = !ltu;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    ex_data    = 32'd0;
    ex_we      = 1'b0;
    ex_next_pc = pc_plus4;
    case (opc)
      OPC_OP, OPC_OPIMM: begin ex_data = alu_res;         ex_we = 1'b1; end
      OPC_LUI:           begin ex_data = imm_u;           ex_we = 1'b1; end
      OPC_AUIPC:         begin ex_data = pc32 + imm_u;    ex_we = 1'b1; end
      OPC_JAL: begin
        ex_data = pc_plus4; ex_we = 1'b1; ex_next_pc = pc32 + imm_j;
      end
      OPC_JALR: begin
        ex_data = pc_plus4; ex_we = 1'b1; ex_next_pc = (rs1_value + imm_i) & ~32'd1;
      end
      OPC_BRANCH: if (taken) ex_next_pc = pc32 + imm_b;
      default: ;
    endcase
    if (rd_field == 5'd0) ex_we = 1'b0;
  end

  always_comb begin
    case (f3)
      F3_SB:   st_data = {4{rs2_value[7:0]}};
      F3_SH:   st_data = {2{rs2_value[15:0]}};
      default: st_data = rs2_value;
    endcase
  end

  assign lane_data = bus_read_data >> {ofs_q, 3'b000};
  always_comb begin
    case (f3_q)
      F3_LB:   ld_data = {{24{lane_data[7]}}, lane_data[7:0]};
      F3_LH:   ld_data = {{16{lane_data[15]}}, lane_data[15:0]};
      F3_LBU:  ld_data = {24'd0, lane_data[7:0]};
      F3_LHU:  ld_data = {16'd0, lane_data[15:0]};
      F3_LW:   ld_data = bus_read_data;
      default: ld_data = bus_read_data;
    endcase
  end

`ifdef EXECUTE_MEM_MISALIGN_CHECK_EN
  logic mis_hit;
  assign mis_hit = ((f3[1:0] == 2'b01) && eff_addr[0]) ||
                   ((f3[1:0] == 2'b10) && (eff_addr[1:0] != 2'b00));
`endif

  always_comb begin
    state_d = state_q;
    rv_d    = 1'b0;
    we_d    = 1'b0;
    mis_d   = 1'b0;
    rd_d    = rd_q;
    npc_d   = npc_q;
    data_d  = data_q;
    baddr_d = baddr_q;
    be_d    = be_q;
    bwd_d   = bwd_q;
    wreq_d  = wreq_q;
    rreq_d  = rreq_q;
    f3_d    = f3_q;
    ofs_d   = ofs_q;
    case (state_q)
      ST_IDLE: if (enable) begin
        rd_d  = rd_field;
        npc_d = ex_next_pc;
        if (is_mem) begin
          f3_d    = f3;
          ofs_d   = eff_addr[1:0];
          baddr_d = eff_addr[BUS_ADDR_WIDTH+1:2];
          be_d    = lane_mask(f3[1:0], eff_addr[1:0]);
          bwd_d   = st_data;
`ifdef EXECUTE_MEM_MISALIGN_CHECK_EN
          if (mis_hit) begin
            rv_d  = 1'b1;
            mis_d = 1'b1;
          end else
`endif
          begin
            state_d = ST_BUS_REQ;
            wreq_d  = is_store;
            rreq_d  = is_load;
          end
        end else begin
          rv_d   = REG_OUT;
          we_d   = REG_OUT && ex_we;
          data_d = ex_data;
        end
      end
      ST_BUS_REQ: if (bus_ready) begin
        wreq_d = 1'b0;
        rreq_d = 1'b0;
        if (rreq_q) begin
          state_d = ST_READ_WAIT;
        end else begin
          state_d = ST_IDLE;
          rv_d    = 1'b1;
        end
      end
      ST_READ_WAIT: if (bus_read_data_valid) begin
        state_d = ST_IDLE;
        rv_d    = 1'b1;
        we_d    = (rd_q != 5'd0);
        data_d  = ld_data;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      rv_q    <= 1'b0;
      we_q    <= 1'b0;
      mis_q   <= 1'b0;
      rd_q    <= 5'd0;
      npc_q   <= 32'd0;
      data_q  <= 32'd0;
      baddr_q <= '0;
      be_q    <= 4'd0;
      bwd_q   <= 32'd0;
      wreq_q  <= 1'b0;
      rreq_q  <= 1'b0;
      f3_q    <= 3'd0;
      ofs_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      rv_q    <= rv_d;
      we_q    <= we_d;
      mis_q   <= mis_d;
      rd_q    <= rd_d;
      npc_q   <= npc_d;
      data_q  <= data_d;
      baddr_q <= baddr_d;
      be_q    <= be_d;
      bwd_q   <= bwd_d;
      wreq_q  <= wreq_d;
      rreq_q  <= rreq_d;
      f3_q    <= f3_d;
      ofs_q   <= ofs_d;
    end
  end

  // Unregistered mode forwards non-memory results straight out in the accept cycle.
  assign bypass          = !REG_OUT && accept && !is_mem && !reset;
  assign ready           = (state_q == ST_IDLE);
  assign result_valid    = rv_q || bypass;
  assign rd              = bypass ? rd_field   : rd_q;
  assign next_pc         = bypass ? ex_next_pc : npc_q;
  assign rd_write_enable = bypass ? ex_we      : we_q;
  assign rd_write_data   = bypass ? ex_data    : data_q;
  assign bus_addr        = baddr_q;
  assign bus_byte_enable = be_q;
  assign bus_write_data  = bwd_q;
  assign bus_write_req   = wreq_q;
  assign bus_read_req    = rreq_q;
`ifdef EXECUTE_MEM_MISALIGN_CHECK_EN
  assign misaligned      = mis_q;
`else
  logic unused_mis;
  assign unused_mis = mis_q;
`endif
endmodule

// File: tb/tb_execute_mem_stage.sv
// Directed scoreboard bench for execute_mem_stage (default parameters).
module tb_execute_mem_stage;
  localparam int W = 71;  // {misaligned, we, rd[4:0], data[31:0], next_pc[31:0]}

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        ready;
  logic [29:0] pc_value = '0;
  logic [31:0] instruction = '0, rs1_value = '0, rs2_value = '0;
  logic        result_valid;
  logic [4:0]  rd;
  logic [31:0] next_pc, rd_write_data, bus_write_data;
  logic        rd_write_enable, bus_write_req, bus_read_req;
  logic [29:0] bus_addr;
  logic [3:0]  bus_byte_enable;
  logic        bus_ready = 1'b0;
  logic [31:0] bus_read_data = '0;
  logic        bus_read_data_valid = 1'b0;
`ifdef EXECUTE_MEM_MISALIGN_CHECK_EN
  logic        misaligned;
`endif

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] e;

  execute_mem_stage dut (
    .clk(clk), .reset(reset), .enable(enable), .ready(ready),
    .pc_value(pc_value), .instruction(instruction),
    .rs1_value(rs1_value), .rs2_value(rs2_value),
    .result_valid(result_valid), .rd(rd), .next_pc(next_pc),
    .rd_write_enable(rd_write_enable), .rd_write_data(rd_write_data),
    .bus_addr(bus_addr), .bus_byte_enable(bus_byte_enable),
    .bus_write_data(bus_write_data), .bus_write_req(bus_write_req),
    .bus_read_req(bus_read_req), .bus_ready(bus_ready),
    .bus_read_data(bus_read_data), .bus_read_data_valid(bus_read_data_valid)
`ifdef EXECUTE_MEM_MISALIGN_CHECK_EN
    , .misaligned(misaligned)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] mk(input logic mis, input logic we, input logic [4:0] r,
                                      input logic [31:0] data, input logic [31:0] npc);
    return {mis, we, r, data, npc};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: every retire pulse is matched against the oldest expected response.
  always @(negedge clk) begin
    if (!reset && result_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_retire actual npc=%h we=%b required no retire", next_pc, rd_write_enable);
      end else begin
        logic ok;
        e  = exp_q.pop_front();
        ok = (next_pc === e[31:0]) && (rd_write_enable === e[69]);
        if (e[69]) ok = ok && (rd === e[68:64]) && (rd_write_data === e[63:32]);
`ifdef EXECUTE_MEM_MISALIGN_CHECK_EN
        ok = ok && (misaligned === e[70]);
`endif
        if (!ok) begin
          errors++;
          $display("FAIL retire actual npc=%h we=%b rd=%0d data=%h required npc=%h we=%b rd=%0d data=%h",
                   next_pc, rd_write_enable, rd, rd_write_data, e[31:0], e[69], e[68:64], e[63:32]);
        end
      end
    end
  end

  task automatic issue(input logic [31:0] pc, input logic [31:0] instr,
                       input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    while (!ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!ready) begin
      checks++; errors++;
      $display("FAIL issue_timeout actual ready=0 required ready=1");
    end
    pc_value = pc[31:2]; instruction = instr; rs1_value = a; rs2_value = b; enable = 1'b1;
    @(posedge clk); #1;
    enable = 1'b0;
  endtask

  task automatic do_load(input string nm, input logic [31:0] pc, input logic [31:0] instr,
                         input logic [31:0] a, input logic [31:0] exp_addr, input logic [3:0] exp_be,
                         input logic [31:0] rdata, input logic [W-1:0] expv);
    exp_q.push_back(expv);
    issue(pc, instr, a, 32'd0);
    @(negedge clk);
    check({nm, "_rreq"}, 32'(bus_read_req), 32'd1);
    check({nm, "_addr"}, 32'(bus_addr), exp_addr);
    check({nm, "_be"}, 32'(bus_byte_enable), 32'(exp_be));
    bus_ready = 1'b1;
    @(posedge clk); #1;
    bus_ready = 1'b0;
    @(negedge clk);
    check({nm, "_wait"}, {30'd0, bus_read_req, ready}, 32'd0);
    @(posedge clk); #1;
    bus_read_data = rdata; bus_read_data_valid = 1'b1;
    @(posedge clk); #1;
    bus_read_data_valid = 1'b0;
    @(negedge clk);
    check({nm, "_retire"}, 32'(result_valid), 32'd1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_ctrl", {27'd0, result_valid, rd_write_enable, bus_write_req, bus_read_req, 1'b0}, 32'd0);
    check("rst_rd", 32'(rd), 32'd0);
    check("rst_npc", next_pc, 32'd0);
    check("rst_data", rd_write_data, 32'd0);
    check("rst_bus", {bus_byte_enable, 28'd0} | 32'(bus_addr) | bus_write_data, 32'd0);
`ifdef EXECUTE_MEM_MISALIGN_CHECK_EN
    check("rst_mis", 32'(misaligned), 32'd0);
`endif
    @(posedge clk); #1;
    reset = 1'b0;

    // ALU / jump / branch vectors
    exp_q.push_back(mk(0, 1, 5, 32'hFFFF_FFFF, 32'h44));
    issue(32'h40, 32'hFFF0_0293, 32'd0, 32'd0);          // ADDI x5,x0,-1
    @(negedge clk);
    check("addi_latency", 32'(result_valid), 32'd1);
    exp_q.push_back(mk(0, 0, 25, 32'd0, 32'hF8));
    issue(32'h100, 32'hFE20_8CE3, 32'd7, 32'd7);         // BEQ x1,x2,-8 taken
    exp_q.push_back(mk(0, 0, 25, 32'd0, 32'h104));
    issue(32'h100, 32'hFE20_9CE3, 32'd7, 32'd7);         // BNE not taken
    exp_q.push_back(mk(0, 1, 3, 32'd7, 32'h204));
    issue(32'h200, 32'h4020_81B3, 32'd10, 32'd3);        // SUB x3,x1,x2
    exp_q.push_back(mk(0, 1, 7, 32'h1234_5000, 32'h20C));
    issue(32'h208, 32'h1234_53B7, 32'd0, 32'd0);         // LUI x7
    exp_q.push_back(mk(0, 1, 1, 32'h214, 32'h220));
    issue(32'h210, 32'h0100_00EF, 32'd0, 32'd0);         // JAL x1,+16
    exp_q.push_back(mk(0, 1, 1, 32'h304, 32'h1004));
    issue(32'h300, 32'h0053_00E7, 32'h1000, 32'd0);      // JALR x1,5(x6)
    exp_q.push_back(mk(0, 1, 4, 32'hF800_0000, 32'h308));
    issue(32'h304, 32'h4040_D213, 32'h8000_0000, 32'd0); // SRAI x4,x1,4

    // SB to 0x1003 with bus_ready held low for 3 cycles
    exp_q.push_back(mk(0, 0, 3, 32'd0, 32'h404));
    issue(32'h400, 32'h0020_81A3, 32'h1000, 32'h0000_00AB);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("sb_wreq", {30'd0, bus_write_req, bus_read_req}, 32'd2);
      check("sb_addr", 32'(bus_addr), 32'h400);
      check("sb_be", 32'(bus_byte_enable), 32'h8);
      check("sb_wdata", bus_write_data, 32'hABAB_ABAB);
      if (i == 3) bus_ready = 1'b1;
    end
    @(posedge clk); #1;
    bus_ready = 1'b0;
    @(negedge clk);
    check("sb_retire", {30'd0, result_valid, bus_write_req}, 32'd2);

    do_load("lh", 32'h500, 32'h0020_9403, 32'h2000, 32'h800, 4'b1100, 32'h8001_0000,
            mk(0, 1, 8, 32'hFFFF_8001, 32'h504));
    do_load("lbu", 32'h508, 32'h0010_C483, 32'h2000, 32'h800, 4'b0010, 32'h0000_8F00,
            mk(0, 1, 9, 32'h0000_008F, 32'h50C));

    // Reset while waiting for load data, then a stale data strobe
    issue(32'h600, 32'h0000_A503, 32'h3000, 32'd0);
    @(negedge clk);
    bus_ready = 1'b1;
    @(posedge clk); #1;
    bus_ready = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    bus_read_data = 32'h5555_AAAA; bus_read_data_valid = 1'b1;
    @(posedge clk); #1;
    bus_read_data_valid = 1'b0;
    @(negedge clk);
    check("rst_mid_ready", 32'(ready), 32'd1);
    check("rst_mid_noretire", {30'd0, result_valid, bus_read_req}, 32'd0);

    // Misaligned word access
`ifdef EXECUTE_MEM_MISALIGN_CHECK_EN
    exp_q.push_back(mk(1, 0, 0, 32'd0, 32'h704));
    issue(32'h700, 32'h0010_A003, 32'h3000, 32'd0);
    @(negedge clk);
    check("mis_noreq", {30'd0, bus_read_req, bus_write_req}, 32'd0);
    check("mis_flag", {30'd0, misaligned, result_valid}, 32'd3);
`else
    do_load("lw_mis", 32'h700, 32'h0010_A003, 32'h3000, 32'hC00, 4'b1110, 32'h1122_3344,
            mk(0, 0, 0, 32'd0, 32'h704));
`endif

    // PC wrap-around
    exp_q.push_back(mk(0, 1, 5, 32'hFFFF_FFFF, 32'h0));
    issue(32'hFFFF_FFFC, 32'hFFF0_0293, 32'd0, 32'd0);

    repeat (3) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
